// File: rtl/alu_ex_result_stage_if.sv
// Handshake/data bundle between the ALU top, the EX result stage and MEM/WB.
// The master drives EX results and out_ready. The slave is the result stage itself.
interface alu_ex_result_stage_if #(
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W+1:0]   adder_result;
  logic [W-1:0]   shft_result;
  logic [W-1:0]   arth_log_result;
  logic [W-1:0]   pc_plus4;
  logic [2:0]     res_sel;
  logic           is_branch;
  logic [2:0]     br_cond;
  logic [4:0]     rd_addr;
  logic           rd_we;

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic [4:0]     out_rd_addr;
  logic           out_rd_we;
  logic           out_br_taken;

  modport master (
    output in_valid, adder_result, shft_result, arth_log_result, pc_plus4,
           res_sel, is_branch, br_cond, rd_addr, rd_we, out_ready,
    input  in_ready, out_valid, out_result, out_rd_addr, out_rd_we, out_br_taken
  );

  modport slave (
    input  in_valid, adder_result, shft_result, arth_log_result, pc_plus4,
           res_sel, is_branch, br_cond, rd_addr, rd_we, out_ready,
    output in_ready, out_valid, out_result, out_rd_addr, out_rd_we, out_br_taken
  );
endinterface

// File: rtl/alu_ex_result_stage.sv
// EX result select, branch resolve and 2-entry skid-buffered register toward MEM/WB.
// Optional macro EX_STALL_CNT_EN adds a saturating stall_cnt output.
module alu_ex_result_stage #(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef EX_STALL_CNT_EN
  output logic [31:0]          stall_cnt,
`endif
  alu_ex_result_stage_if.slave ex
);

  typedef struct packed {
    logic [W-1:0] result;
    logic [4:0]   rd_addr;
    logic         rd_we;
    logic         br_taken;
  } entry_t;

  entry_t       r_main;
  entry_t       r_skid;
  logic         r_main_valid;
  logic         r_skid_valid;
  logic         r_in_ready;

  entry_t       w_entry;
  entry_t       w_main_nxt;
  entry_t       w_skid_nxt;
  logic         w_main_valid_nxt;
  logic         w_skid_valid_nxt;
  logic [W-1:0] w_result;
  logic         w_lt;
  logic         w_eq;
  logic         w_cond;
  logic         w_accept;
  logic         w_xfer;

  // Both compare terms come from the single upstream subtract.
  assign w_lt = ex.adder_result[W+1];
  assign w_eq = (ex.adder_result == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_result = '0;
    case (ex.res_sel)
      3'd0:    w_result = ex.arth_log_result;
      3'd1:    w_result = ex.shft_result;
      3'd2:    w_result = {{(W-1){1'b0}}, w_lt};
      3'd3:    w_result = ex.pc_plus4;
      3'd4:    w_result = ex.adder_result[W-1:0];
      default: w_result = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (ex.br_cond)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_lt;
      3'b111:  w_cond = !w_lt;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_entry.result   = w_result;
    w_entry.rd_addr  = ex.rd_addr;
    w_entry.rd_we    = ex.rd_we & !ex.is_branch;
    w_entry.br_taken = ex.is_branch & w_cond;
  end

  assign w_accept = ex.in_valid & r_in_ready;
  assign w_xfer   = r_main_valid & ex.out_ready;

  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (r_skid_valid) begin
      // in_ready is low here, so nothing is accepted; only the skid can drain.
      if (w_xfer) begin
        w_main_nxt       = r_skid;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid || w_xfer) begin
        w_main_nxt       = w_entry;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_skid_nxt       = w_entry;
        w_skid_valid_nxt = 1'b1;
      end
    end else if (w_xfer) begin
      w_main_valid_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign ex.in_ready     = r_in_ready;
  assign ex.out_valid    = r_main_valid;
  assign ex.out_result   = r_main.result;
  assign ex.out_rd_addr  = r_main.rd_addr;
  assign ex.out_rd_we    = r_main.rd_we;
  assign ex.out_br_taken = r_main.br_taken;

`ifdef EX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !ex.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_ex_result_stage.sv
// Directed self-checking bench for alu_ex_result_stage: select, branch, skid, streaming, reset.
// Build with +define+EX_STALL_CNT_EN to also cover the stall counter.
module tb_alu_ex_result_stage;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  alu_ex_result_stage_if #(.W(W)) bus ();

  alu_ex_result_stage #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef EX_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .ex        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [2:0] sel, input logic [W+1:0] adder,
                       input logic [W-1:0] shft, input logic [W-1:0] arth, input logic [W-1:0] pc,
                       input logic is_br, input logic [2:0] cond, input logic [4:0] rd,
                       input logic we);
    bus.in_valid        = valid;
    bus.res_sel         = sel;
    bus.adder_result    = adder;
    bus.shft_result     = shft;
    bus.arth_log_result = arth;
    bus.pc_plus4        = pc;
    bus.is_branch       = is_br;
    bus.br_cond         = cond;
    bus.rd_addr         = rd;
    bus.rd_we           = we;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_result"}, 64'(bus.out_result), 64'd0);
    check({tag, "_rd"}, 64'(bus.out_rd_addr), 64'd0);
    check({tag, "_we"}, 64'(bus.out_rd_we), 64'd0);
    check({tag, "_taken"}, 64'(bus.out_br_taken), 64'd0);
  endtask

  typedef struct {
    logic [2:0]   cond;
    logic         is_br;
    logic [W+1:0] adder;
    logic         taken;
    logic         we;
  } br_vec_t;

  typedef struct {
    logic [2:0]   sel;
    logic [W+1:0] adder;
    logic [W-1:0] exp;
  } sel_vec_t;

  br_vec_t br_vecs[9] = '{
    '{3'b000, 1'b1, 34'h0,           1'b1, 1'b0},
    '{3'b001, 1'b1, 34'h0,           1'b0, 1'b0},
    '{3'b000, 1'b1, 34'h5,           1'b0, 1'b0},
    '{3'b100, 1'b1, 34'h2_0000_0000, 1'b1, 1'b0},
    '{3'b101, 1'b1, 34'h2_0000_0000, 1'b0, 1'b0},
    '{3'b110, 1'b1, 34'h1,           1'b0, 1'b0},
    '{3'b111, 1'b1, 34'h1,           1'b1, 1'b0},
    '{3'b010, 1'b1, 34'h0,           1'b0, 1'b0},
    '{3'b000, 1'b0, 34'h0,           1'b0, 1'b1}
  };

  sel_vec_t sel_vecs[6] = '{
    '{3'd0, 34'h0,           32'hAAAA_5555},
    '{3'd1, 34'h0,           32'h0000_0F0F},
    '{3'd3, 34'h0,           32'h0000_1004},
    '{3'd4, 34'h1_2345_6789, 32'h2345_6789},
    '{3'd5, 34'h1_2345_6789, 32'h0},
    '{3'd7, 34'h1_2345_6789, 32'h0}
  };

  initial begin
    drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 3'd0, 5'd0, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check_reset_state("reset");

`ifdef EX_STALL_CNT_EN
    check("stall_cnt_reset", 64'(stall_cnt), 64'd0);
    drive(1'b1, 3'd0, '0, '0, 32'h77, '0, 1'b0, 3'd0, 5'd1, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    repeat (10) cyc();
    check("stall_cnt_10", 64'(stall_cnt), 64'd10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("stall_cnt_cleared", 64'(stall_cnt), 64'd0);
`endif

    // SLT: borrow bit set means lhs < rhs.
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd2, 34'h3_FFFF_FFFF, '0, '0, '0, 1'b0, 3'd0, 5'd5, 1'b1);
    cyc();
    check("slt_valid", 64'(bus.out_valid), 64'd1);
    check("slt_result", 64'(bus.out_result), 64'd1);
    check("slt_rd", 64'(bus.out_rd_addr), 64'd5);
    check("slt_we", 64'(bus.out_rd_we), 64'd1);

    foreach (br_vecs[i]) begin
      drive(1'b1, 3'd4, br_vecs[i].adder, '0, '0, '0, br_vecs[i].is_br, br_vecs[i].cond,
            5'd9, 1'b1);
      cyc();
      check($sformatf("br%0d_taken", i), 64'(bus.out_br_taken), 64'(br_vecs[i].taken));
      check($sformatf("br%0d_we", i), 64'(bus.out_rd_we), 64'(br_vecs[i].we));
    end

    foreach (sel_vecs[i]) begin
      drive(1'b1, sel_vecs[i].sel, sel_vecs[i].adder, 32'h0000_0F0F, 32'hAAAA_5555,
            32'h0000_1004, 1'b0, 3'd0, 5'd3, 1'b1);
      cyc();
      check($sformatf("sel%0d_result", i), 64'(bus.out_result), 64'(sel_vecs[i].exp));
    end

    bus.in_valid = 1'b0;
    cyc();
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: A in main, B in skid, then drain in order.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, '0, '0, 32'hA, '0, 1'b0, 3'd0, 5'd10, 1'b1);
    cyc();
    check("bp_a_result", 64'(bus.out_result), 64'hA);
    check("bp_a_in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 3'd0, '0, '0, 32'hB, '0, 1'b0, 3'd0, 5'd11, 1'b1);
    cyc();
    check("bp_b_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_b_result_hold", 64'(bus.out_result), 64'hA);
    bus.in_valid = 1'b0;
    cyc();
    check("bp_hold_result", 64'(bus.out_result), 64'hA);
    check("bp_hold_rd", 64'(bus.out_rd_addr), 64'd10);
    check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    cyc();
    check("bp_drain_b_valid", 64'(bus.out_valid), 64'd1);
    check("bp_drain_b_result", 64'(bus.out_result), 64'hB);
    check("bp_drain_b_rd", 64'(bus.out_rd_addr), 64'd11);
    check("bp_drain_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check("bp_empty_valid", 64'(bus.out_valid), 64'd0);

    // Streaming: one result per cycle, no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd1, '0, 32'(i), '0, '0, 1'b0, 3'd0, 5'(i), 1'b1);
      cyc();
      check($sformatf("stream%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("stream%0d_result", i), 64'(bus.out_result), 64'(i));
      check($sformatf("stream%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    cyc();

    // Reset with both entries occupied drops them.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, '0, '0, 32'h1234, '0, 1'b1, 3'd0, 5'd7, 1'b1);
    cyc();
    drive(1'b1, 3'd0, '0, '0, 32'h5678, '0, 1'b0, 3'd0, 5'd8, 1'b1);
    cyc();
    check("mid_full_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_full_valid", 64'(bus.out_valid), 64'd1);
    check("mid_full_taken", 64'(bus.out_br_taken), 64'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
